regfile_wb_arbiter: RTL

//   Shares the single synchronous write port of the 32x32 register file between NREQ

---
 rtl/regfile_wb_arbiter_pkg.sv | 19 +
 rtl/regfile_wb_arbiter_rr.sv | 38 +++
 rtl/regfile_wb_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file constants and index helpers for the write-back arbiter.
// Both the arbiter top and its round-robin core import this package.
package regfile_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int IDX_W      = 3;

  localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

  // Advance a requester index by one, wrapping from n-1 back to 0.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx, input int n);
    if (int'(idx) >= n - 1) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Combinational round-robin arbiter: the first asserted request at or after ptr_i
// (modulo N) wins, reported both one-hot and as an encoded index.
module rr_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  int pos;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    pos     = 0;
    for (int i = 0; i < N; i++) begin
      pos = int'(ptr_i) + i;
      if (pos >= N) begin
        pos = pos - N;
      end
      // Constant inner indices keep the request select free of width truncation.
      for (int j = 0; j < N; j++) begin
        if (!any_o && (j == pos) && req_i[j]) begin
          any_o      = 1'b1;
          grant_o[j] = 1'b1;
          idx_o      = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between NREQ units,
// with an x0 sink, hold/flush gating and a single registered write stage.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 3
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [NREQ-1:0]            req_valid_i,
  input  logic [NREQ*REG_ADDR_W-1:0] req_rd_addr_i,
  input  logic [NREQ*WIDTH-1:0]      req_data_i,
  output logic [NREQ-1:0]            req_ready_o,
  input  logic                       hold_i,
  input  logic                       flush_i,
  output logic                       rf_w_en_o,
  output logic [REG_ADDR_W-1:0]      rf_rd_addr_o,
  output logic [WIDTH-1:0]           rf_w_data_o,
  output logic [IDX_W-1:0]           grant_idx_o
);

  logic [NREQ-1:0]       x0_hit;
  logic [NREQ-1:0]       cand;
  logic [NREQ-1:0]       arb_grant;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_any;
  logic                  blocked;
  logic                  grant_vld;
  logic [REG_ADDR_W-1:0] sel_addr;
  logic [WIDTH-1:0]      sel_data;

  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                  w_en_q;
  logic [REG_ADDR_W-1:0] w_addr_q;
  logic [WIDTH-1:0]      w_data_q;
  logic [IDX_W-1:0]      grant_idx_q;

  // Writes to x0 bypass arbitration entirely; only nonzero destinations compete.
  always_comb begin
    x0_hit = '0;
    cand   = '0;
    for (int k = 0; k < NREQ; k++) begin
      x0_hit[k] = req_valid_i[k] && (req_rd_addr_i[REG_ADDR_W*k +: REG_ADDR_W] == REG_X0);
      cand[k]   = req_valid_i[k] && (req_rd_addr_i[REG_ADDR_W*k +: REG_ADDR_W] != REG_X0);
    end
  end

  rr_arbiter #(
    .N (NREQ)
  ) u_rr (
    .req_i   (cand),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  assign blocked     = reset_i | hold_i | flush_i;
  assign grant_vld   = arb_any & ~blocked;
  assign req_ready_o = blocked ? '0 : (x0_hit | arb_grant);

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (arb_grant[k]) begin
        sel_addr = req_rd_addr_i[REG_ADDR_W*k +: REG_ADDR_W];
        sel_data = req_data_i[WIDTH*k +: WIDTH];
      end
    end
  end

  assign rr_ptr_d = grant_vld ? wrap_inc(arb_idx, NREQ) : rr_ptr_q;

  // Address, data and owner index keep their last values when nothing is granted.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_ptr_q    <= '0;
      w_en_q      <= 1'b0;
      w_addr_q    <= '0;
      w_data_q    <= '0;
      grant_idx_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      w_en_q   <= grant_vld;
      if (grant_vld) begin
        w_addr_q    <= sel_addr;
        w_data_q    <= sel_data;
        grant_idx_q <= arb_idx;
      end
    end
  end

  assign rf_w_en_o    = w_en_q;
  assign rf_rd_addr_o = w_addr_q;
  assign rf_w_data_o  = w_data_q;
  assign grant_idx_o  = grant_idx_q;

endmodule
